// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
//   op_e  : operation select (OP_ADD = a + b + cin, OP_SUB = a - b)
//   seg_w : bit width of one pipeline segment
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width of one pipeline segment; WIDTH must be a multiple of NSEG*BLOCK.
   function automatic int unsigned seg_w(input int unsigned width, input int unsigned nseg);
      return width / nseg;
   endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational W-bit carry-lookahead adder built from BLOCK-bit groups.
// Ports:
//   a, b          in   W   addends
//   cin           in   1   carry into bit 0
//   s             out  W   sum
//   cout          out  1   carry out of bit W-1
//   msb_carry_in  out  1   carry into bit W-1 (for signed overflow)
module cla_block #(
   parameter int unsigned W     = 4,
   parameter int unsigned BLOCK = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         msb_carry_in
);

   localparam int unsigned NGRP = W / BLOCK;

   logic [W-1:0]    p;
   logic [W-1:0]    g;
   logic [NGRP-1:0] grp_p;
   logic [NGRP-1:0] grp_g;
   logic [NGRP:0]   grp_c;
   logic [W:0]      c;

   assign p = a ^ b;
   assign g = a & b;

   // Group propagate / generate.
   always_comb begin
      grp_p = '0;
      grp_g = '0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         grp_p[j] = &p[j*BLOCK +: BLOCK];
         grp_g[j] = 1'b0;
         for (int unsigned i = 0; i < BLOCK; i++) begin
            grp_g[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & grp_g[j]);
         end
      end
   end

   // Carries across groups, then within each group from its group carry.
   always_comb begin
      grp_c    = '0;
      c        = '0;
      grp_c[0] = cin;
      for (int unsigned j = 0; j < NGRP; j++) begin
         grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      end
      for (int unsigned j = 0; j < NGRP; j++) begin
         c[j*BLOCK] = grp_c[j];
         for (int unsigned i = 1; i < BLOCK; i++) begin
            c[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & c[j*BLOCK+i-1]);
         end
      end
      c[W] = grp_c[NGRP];
   end

   assign s            = p ^ c[W-1:0];
   assign cout         = c[W];
   assign msb_carry_in = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready streams.
// Each of NSEG stages adds one segment; the inter-segment carry, the
// not-yet-added operand bits and the finished sum bits travel in per-stage
// registers. Latency NSEG cycles, one beat per cycle, global stall.
// Optional feature macro: CLA_ADDER_SAT_EN (saturate out_s on signed overflow).
// Ports:
//   hz100      in   1      clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid
//   in_a/in_b  in   WIDTH  operands
//   in_cin     in   1      carry-in (ADD only)
//   in_op      in   op_e   OP_ADD / OP_SUB
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   out_s      out  WIDTH  sum / difference
//   out_cout   out  1      carry out (SUB: 1 = no borrow)
//   out_ovf    out  1      signed overflow
//   out_zero   out  1      out_s == 0
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NSEG  = 4,
   parameter int unsigned BLOCK = 4
) (
   input  logic             hz100,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  op_e              in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int unsigned SEG_W = seg_w(WIDTH, NSEG);

   logic             advance;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipeline moves together unless the output holds an unaccepted beat.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Subtraction as a + ~b + 1.
   assign is_sub  = (in_op == OP_SUB);
   assign b_eff   = is_sub ? ~in_b : in_b;
   assign cin_eff = is_sub ? 1'b1 : in_cin;

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int unsigned REM_W = WIDTH - k * SEG_W;      // operand bits not yet added
      localparam int unsigned ACC_W = (k + 1) * SEG_W;        // sum bits done after this stage

      logic             v_in;
      logic             c_in;
      logic             c_out;
      logic             mci;
      logic [REM_W-1:0] rem_a;
      logic [REM_W-1:0] rem_b;
      logic [SEG_W-1:0] s_seg;
      logic [ACC_W-1:0] s_acc;

      // Stage inputs: ports for the first stage, previous stage registers otherwise.
      if (k == 0) begin : g_head
         assign v_in  = in_valid;
         assign c_in  = cin_eff;
         assign rem_a = in_a;
         assign rem_b = b_eff;
         assign s_acc = s_seg;
      end else begin : g_body
         assign v_in  = g_stage[k-1].g_mid.v_q;
         assign c_in  = g_stage[k-1].g_mid.c_q;
         assign rem_a = g_stage[k-1].g_mid.a_hi_q;
         assign rem_b = g_stage[k-1].g_mid.b_hi_q;
         assign s_acc = {s_seg, g_stage[k-1].g_mid.s_lo_q};
      end

      cla_block #(
         .W     (SEG_W),
         .BLOCK (BLOCK)
      ) u_cla (
         .a            (rem_a[SEG_W-1:0]),
         .b            (rem_b[SEG_W-1:0]),
         .cin          (c_in),
         .s            (s_seg),
         .cout         (c_out),
         .msb_carry_in (mci)
      );

      if (k < NSEG - 1) begin : g_mid
         logic                   v_q;
         logic                   c_q;
         logic [REM_W-SEG_W-1:0] a_hi_q;
         logic [REM_W-SEG_W-1:0] b_hi_q;
         logic [ACC_W-1:0]       s_lo_q;
         logic                   mci_unused;

         // Only the top segment's carry into its MSB matters.
         assign mci_unused = mci;

         // Skew registers; data only captured for valid beats.
         always_ff @(posedge hz100 or negedge reset) begin
            if (!reset) begin
               v_q    <= 1'b0;
               c_q    <= 1'b0;
               a_hi_q <= '0;
               b_hi_q <= '0;
               s_lo_q <= '0;
            end else if (advance) begin
               v_q <= v_in;
               if (v_in) begin
                  c_q    <= c_out;
                  a_hi_q <= rem_a[REM_W-1:SEG_W];
                  b_hi_q <= rem_b[REM_W-1:SEG_W];
                  s_lo_q <= s_acc;
               end
            end
         end
      end else begin : g_tail
         logic [WIDTH-1:0] s_d;
         logic             ovf_d;
         logic             zero_d;

         // Signed overflow: carry into MSB differs from carry out of MSB.
         assign ovf_d = mci ^ c_out;

`ifdef CLA_ADDER_SAT_EN
         // On overflow both operands share a sign; clamp toward it.
         always_comb begin
            s_d = s_acc;
            if (ovf_d) begin
               s_d = rem_a[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign s_d = s_acc;
`endif

         assign zero_d = (s_d == '0);

         // Output registers hold while stalled.
         always_ff @(posedge hz100 or negedge reset) begin
            if (!reset) begin
               out_valid <= 1'b0;
               out_s     <= '0;
               out_cout  <= 1'b0;
               out_ovf   <= 1'b0;
               out_zero  <= 1'b0;
            end else if (advance) begin
               out_valid <= v_in;
               if (v_in) begin
                  out_s    <= s_d;
                  out_cout <= c_out;
                  out_ovf  <= ovf_d;
                  out_zero <= zero_d;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, NSEG=4, BLOCK=4).
module tb_pipelined_cla_adder;
   import cla_pkg::*;

   localparam int unsigned W     = 16;
   localparam int unsigned NSEG  = 4;
   localparam int unsigned BLOCK = 4;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         hz100 = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   op_e          in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_s;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   int   sent     = 0;
   res_t exp_q[$];
   logic stall_seen;
   res_t stall_res;

   pipelined_cla_adder #(
      .WIDTH (W),
      .NSEG  (NSEG),
      .BLOCK (BLOCK)
   ) dut (
      .hz100     (hz100),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   always #5 hz100 = ~hz100;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin);
      res_t     r;
      logic [W:0] full;
      longint   sa, sb, sr, smax, smin;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -smax - 1;
      if (op == OP_ADD) begin
         full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         r.s    = full[W-1:0];
         r.cout = full[W];
         sr     = sa + sb + longint'(cin);
      end else begin
         r.s    = a - b;
         r.cout = (a >= b);
         sr     = sa - sb;
      end
      r.ovf = (sr > smax) || (sr < smin);
`ifdef CLA_ADDER_SAT_EN
      if (r.ovf) r.s = (sr > smax) ? W'(smax) : W'(smin);
`endif
      r.zero = (r.s == '0);
      return r;
   endfunction

   function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
      res_t r;
      r.s = s; r.cout = c; r.ovf = o; r.zero = z;
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b0, {(W-1){1'b1}}};
         3:       v = {1'b1, {(W-1){1'b0}}};
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   // Called at the falling edge: scores the handshakes that the next rising edge performs.
   task automatic monitor();
      res_t got;
      res_t e;
      got = {out_s, out_cout, out_ovf, out_zero};
      if (stall_seen) begin
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_hold", 64'(got), 64'(stall_res));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            chk("spurious_out", 64'(out_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_s", 64'(out_s), 64'(e.s));
            chk("out_cout", 64'(out_cout), 64'(e.cout));
            chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
            chk("out_zero", 64'(out_zero), 64'(e.zero));
         end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_cin));
      stall_seen = out_valid && !out_ready;
      stall_res  = got;
   endtask

   // One beat into an empty pipeline; checks latency and result.
   task automatic send_check(input string tag, input op_e op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic cin, input res_t exp);
      int lat;
      @(posedge hz100); #1;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b1;
      @(negedge hz100);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge hz100); #1;
      in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
      lat = 0;
      for (int i = 1; i <= int'(4 * NSEG + 8); i++) begin
         @(negedge hz100);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'(NSEG));
      chk({tag, "_s"}, 64'(out_s), 64'(exp.s));
      chk({tag, "_cout"}, 64'(out_cout), 64'(exp.cout));
      chk({tag, "_ovf"}, 64'(out_ovf), 64'(exp.ovf));
      chk({tag, "_zero"}, 64'(out_zero), 64'(exp.zero));
      @(posedge hz100); #1;
      stall_seen = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
      in_op = OP_ADD; out_ready = 1'b0; stall_seen = 1'b0; stall_res = '0;
      repeat (3) @(negedge hz100);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_s", 64'(out_s), 64'd0);
      chk("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b1;

      // Directed boundary cases.
`ifdef CLA_ADDER_SAT_EN
      send_check("add_9999", OP_ADD, 16'h9999, 16'h9999, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0));
      send_check("add_7fff", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1, 1'b0));
      send_check("sub_8000", OP_SUB, 16'h8000, 16'h0001, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0));
`else
      send_check("add_9999", OP_ADD, 16'h9999, 16'h9999, 1'b0, mk(16'h3332, 1'b1, 1'b1, 1'b0));
      send_check("add_7fff", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
      send_check("sub_8000", OP_SUB, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
`endif
      send_check("sub_0_1", OP_SUB, 16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
      send_check("sub_eq", OP_SUB, 16'h1234, 16'h1234, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      send_check("add_cin_wrap", OP_ADD, 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      send_check("sub_cin_ign", OP_SUB, 16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0));
      send_check("add_seg_carry", OP_ADD, 16'h0FFF, 16'h0000, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0));
      send_check("add_00ff", OP_ADD, 16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0, 1'b0));

      // Eight back-to-back beats with the output stalled in cycles 5..7.
      n_out = 0; sent = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge hz100); #1;
         in_valid  = (sent < 8);
         in_op     = op_e'($urandom_range(0, 1));
         in_a      = pick();
         in_b      = pick();
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = !(cyc >= 5 && cyc <= 7);
         @(negedge hz100);
         if (cyc < 12) chk("b2b_in_ready", 64'(in_ready), 64'(!(cyc >= 5 && cyc <= 7)));
         if (in_valid && in_ready) sent++;
         monitor();
      end
      chk("b2b_count", 64'(n_out), 64'd8);
      chk("b2b_empty", 64'(exp_q.size()), 64'd0);

      // Reset with three beats in flight.
      for (int i = 0; i < int'(NSEG + 1); i++) begin
         @(posedge hz100); #1;
         in_valid  = (i < 3);
         in_op     = op_e'($urandom_range(0, 1));
         in_a      = pick();
         in_b      = pick();
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = 1'b0;
         @(negedge hz100);
         monitor();
      end
      chk("rst_pre_valid", 64'(out_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_s", 64'(out_s), 64'd0);
      exp_q.delete();
      stall_seen = 1'b0;
      in_valid   = 1'b0;
      @(posedge hz100);
      @(negedge hz100);
      reset     = 1'b1;
      out_ready = 1'b1;
      in_a = pick(); in_b = pick();
      send_check("post_rst", OP_ADD, in_a, in_b, 1'b1, model(OP_ADD, in_a, in_b, 1'b1));

      // Random traffic with random backpressure.
      n_out = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge hz100); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_op     = op_e'($urandom_range(0, 1));
         in_a      = pick();
         in_b      = pick();
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge hz100);
         monitor();
      end
      for (int i = 0; i < int'(4 * NSEG + 8) && exp_q.size() != 0; i++) begin
         @(posedge hz100); #1;
         in_valid = 1'b0; out_ready = 1'b1;
         @(negedge hz100);
         monitor();
      end
      @(posedge hz100); #1;
      in_valid = 1'b0;
      @(negedge hz100);
      monitor();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_idle", 64'(out_valid), 64'd0);
      chk("rand_some_out", 64'(n_out > 1000), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
